pwm_meter: RTL and testbench

Measures an incoming PWM waveform: on-time and period, in clock cycles, one result per complete period. It is the receive-side counterpart of the team's `pwm` generator. Uses:

- Loop-back checking of the RGB LED channels.
- Reading an external PWM source, such as a servo tester or a sensor.

An asynchronous pin goes in; registered on_count/period_count, a one-cycle sample_valid pulse and a stuck-level indication come out.

---
 rtl/pwm_meter_pkg.sv | 18 +
 rtl/sync2.sv | 30 +++
 rtl/pwm_meter.sv | 118 +++++++++++
 tb/tb_pwm_meter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_meter_pkg.sv
// pwm_meter_pkg
// Shared types and helpers for the PWM measurement block.
//   meter_state_t : measurement FSM state encoding
//   cnt_max()     : saturation value of a CNT_W-bit cycle counter
package pwm_meter_pkg;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        ON        = 2'd1,
        OFF       = 2'd2
    } meter_state_t;

    // All-ones value for a counter of width w; 64-bit so CNT_W up to 63 is safe.
    function automatic longint unsigned cnt_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2
// Two-flop synchronizer with a configurable reset value, so the synchronized
// output can come out of reset at the input's idle level (no false edge).
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   d      in  asynchronous input
//   q      out synchronized output, RST_VAL while in reset
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pwm_meter.sv
// pwm_meter
// Measures on-time and period (in clk cycles) of an asynchronous PWM input,
// producing one result per complete period, plus a stuck-level indication
// when no "on" edge arrives for cnt_max(CNT_W) cycles.
// Ports:
//   clk           in  system clock
//   rst_n         in  synchronous active-low reset
//   pwm_in        in  asynchronous PWM pin
//   on_count      out on-time of the last complete period
//   period_count  out rise-to-rise length of the last complete period
//   sample_valid  out one-cycle pulse when on_count/period_count update
//   level_stuck   out no "on" edge for cnt_max(CNT_W) cycles
//   stuck_level   out logical level (1 = on) while level_stuck, else 0
//
// state     | meaning
// ----------+---------------------------------------------------------
// WAIT_RISE | no period in progress (after reset or stuck); await rise
// ON        | inside the on-phase, counting on-time
// OFF       | inside the off-phase, waiting for the closing rise
module pwm_meter
    import pwm_meter_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] on_count,
    output logic [CNT_W-1:0] period_count,
    output logic             sample_valid,
    output logic             level_stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             pin_sync;
    logic             lvl;
    logic             lvl_d;
    logic             rise;
    logic             fall;
    meter_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] on_acc;

    // Reset to the idle pin level so lvl and lvl_d both start at "off".
    sync2 #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pwm_in),
        .q     (pin_sync)
    );

    assign lvl  = pin_sync ^ ACTIVE_LOW;
    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= WAIT_RISE;
            cnt          <= '0;
            on_acc       <= '0;
            on_count     <= '0;
            period_count <= '0;
            sample_valid <= 1'b0;
            level_stuck  <= 1'b0;
            stuck_level  <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end

            if (rise) begin
                // A rise always starts a fresh period, including out of stuck.
                cnt         <= CNT_ONE;
                state       <= ON;
                level_stuck <= 1'b0;
                stuck_level <= 1'b0;
                // A saturated count cannot be a real period; drop it.
                if (state == OFF && cnt != CNT_MAX) begin
                    on_count     <= on_acc;
                    period_count <= cnt;
                    sample_valid <= 1'b1;
                end
            end else if (cnt == CNT_MAX) begin
                // Counter stays saturated, so stuck_level follows lvl each cycle.
                level_stuck <= 1'b1;
                stuck_level <= lvl;
                state       <= WAIT_RISE;
            end else begin
                case (state)
                    ON: begin
                        if (fall) begin
                            on_acc <= cnt;
                            state  <= OFF;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_meter.sv
module tb_pwm_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // dut_a: CNT_W=16, active low; dut_b: CNT_W=16, active high; dut_c: CNT_W=4, active low
    logic        rst_a, pin_a, sv_a, ls_a, sl_a;
    logic [15:0] on_a, per_a;
    logic        rst_b, pin_b, sv_b, ls_b, sl_b;
    logic [15:0] on_b, per_b;
    logic        rst_c, pin_c, sv_c, ls_c, sl_c;
    logic [3:0]  on_c, per_c;

    pwm_meter #(.CNT_W(16), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_a), .pwm_in(pin_a), .on_count(on_a), .period_count(per_a),
        .sample_valid(sv_a), .level_stuck(ls_a), .stuck_level(sl_a));
    pwm_meter #(.CNT_W(16), .ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_b), .pwm_in(pin_b), .on_count(on_b), .period_count(per_b),
        .sample_valid(sv_b), .level_stuck(ls_b), .stuck_level(sl_b));
    pwm_meter #(.CNT_W(4), .ACTIVE_LOW(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_c), .pwm_in(pin_c), .on_count(on_c), .period_count(per_c),
        .sample_valid(sv_c), .level_stuck(ls_c), .stuck_level(sl_c));

    // Observed samples: {cycle, on, period}
    logic [63:0] obs_a[$], obs_b[$], obs_c[$];
    int   b2b_a = 0, b2b_b = 0, b2b_c = 0;
    logic sv_a_d = 1'b0, sv_b_d = 1'b0, sv_c_d = 1'b0;
    bit   stuck_seen_c = 1'b0;

    always @(negedge clk) begin
        if (sv_a === 1'b1) begin
            obs_a.push_back({cyc, on_a, per_a});
            if (sv_a_d === 1'b1) b2b_a++;
        end
        if (sv_b === 1'b1) begin
            obs_b.push_back({cyc, on_b, per_b});
            if (sv_b_d === 1'b1) b2b_b++;
        end
        if (sv_c === 1'b1) begin
            obs_c.push_back({cyc, 12'd0, on_c, 12'd0, per_c});
            if (sv_c_d === 1'b1) b2b_c++;
        end
        if (ls_c === 1'b1) stuck_seen_c = 1'b1;
        sv_a_d = sv_a;
        sv_b_d = sv_b;
        sv_c_d = sv_c;
    end

    // Reference model input: list of (on, off) lengths; expected {on, period}
    int          q_on[$], q_off[$];
    logic [31:0] exp_q[$];

    task automatic drive(input int d, input bit on, input int n);
        case (d)
            0:       pin_a = ~on;
            1:       pin_b = on;
            default: pin_c = ~on;
        endcase
        repeat (n) @(negedge clk);
    endtask

    task automatic fill(input int n, input int on_len, input int off_len);
        for (int i = 0; i < n; i++) begin
            q_on.push_back(on_len);
            q_off.push_back(off_len);
        end
    endtask

    // Each period closed by a following rise yields a sample iff its length is
    // below the counter's saturation value. The tail adds that closing rise.
    task automatic play(input int d, input int maxv, input bit tail);
        for (int i = 0; i < q_on.size(); i++) begin
            drive(d, 1'b1, q_on[i]);
            drive(d, 1'b0, q_off[i]);
            if (q_on[i] + q_off[i] < maxv)
                exp_q.push_back({16'(q_on[i]), 16'(q_on[i] + q_off[i])});
        end
        q_on.delete();
        q_off.delete();
        if (tail) begin
            drive(d, 1'b1, 2);
            drive(d, 1'b0, 8);
        end
    endtask

    task automatic do_reset(input int d);
        case (d)
            0:       begin rst_a = 1'b0; pin_a = 1'b1; end
            1:       begin rst_b = 1'b0; pin_b = 1'b0; end
            default: begin rst_c = 1'b0; pin_c = 1'b1; end
        endcase
        repeat (2) @(negedge clk);
        case (d)
            0:       rst_a = 1'b1;
            1:       rst_b = 1'b1;
            default: rst_c = 1'b1;
        endcase
        repeat (3) @(negedge clk);
        obs_a.delete(); obs_b.delete(); obs_c.delete();
        b2b_a = 0; b2b_b = 0; b2b_c = 0;
        exp_q.delete();
    endtask

    task automatic test_reset;
        total++;
        if ({on_a, per_a, sv_a, ls_a, sl_a} !== 35'd0) begin
            bad++; $display("FAIL reset_a got=%h want=0", {on_a, per_a, sv_a, ls_a, sl_a});
        end
        total++;
        if ({on_b, per_b, sv_b, ls_b, sl_b} !== 35'd0) begin
            bad++; $display("FAIL reset_b got=%h want=0", {on_b, per_b, sv_b, ls_b, sl_b});
        end
        total++;
        if ({on_c, per_c, sv_c, ls_c, sl_c} !== 11'd0) begin
            bad++; $display("FAIL reset_c got=%h want=0", {on_c, per_c, sv_c, ls_c, sl_c});
        end
    endtask

    task automatic test_fixed_3_5;
        logic [63:0] got[$];
        do_reset(0);
        fill(10, 3, 5);
        play(0, 65535, 1'b1);
        got = obs_a;
        total++;
        if (got.size() != exp_q.size()) begin
            bad++; $display("FAIL fixed_count got=%0d want=%0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i][31:0] !== exp_q[i]) begin
                bad++; $display("FAIL fixed_sample[%0d] got on=%0d per=%0d want on=%0d per=%0d",
                    i, got[i][31:16], got[i][15:0], exp_q[i][31:16], exp_q[i][15:0]);
            end
            if (i > 0) begin
                total++;
                if (got[i][63:32] - got[i-1][63:32] !== 32'd8) begin
                    bad++; $display("FAIL fixed_spacing[%0d] got=%0d want=8", i, got[i][63:32] - got[i-1][63:32]);
                end
            end
        end
    endtask

    task automatic test_active_high_1_1;
        logic [63:0] got[$];
        do_reset(1);
        fill(12, 1, 1);
        play(1, 65535, 1'b1);
        got = obs_b;
        total++;
        if (got.size() != exp_q.size()) begin
            bad++; $display("FAIL ah_count got=%0d want=%0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i][31:0] !== exp_q[i]) begin
                bad++; $display("FAIL ah_sample[%0d] got on=%0d per=%0d want on=%0d per=%0d",
                    i, got[i][31:16], got[i][15:0], exp_q[i][31:16], exp_q[i][15:0]);
            end
            if (i > 0) begin
                total++;
                if (got[i][63:32] - got[i-1][63:32] !== 32'd2) begin
                    bad++; $display("FAIL ah_spacing[%0d] got=%0d want=2", i, got[i][63:32] - got[i-1][63:32]);
                end
            end
        end
        total++;
        if (b2b_b != 0) begin
            bad++; $display("FAIL ah_back_to_back got=%0d want=0", b2b_b);
        end
    endtask

    task automatic test_random(input int d);
        logic [63:0] got[$];
        do_reset(d);
        for (int i = 0; i < 30; i++)
            fill(1, $urandom_range(1, 12), $urandom_range(1, 12));
        play(d, 65535, 1'b1);
        got = (d == 0) ? obs_a : obs_b;
        total++;
        if (got.size() != exp_q.size()) begin
            bad++; $display("FAIL rand%0d_count got=%0d want=%0d", d, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i][31:0] !== exp_q[i]) begin
                bad++; $display("FAIL rand%0d_sample[%0d] got on=%0d per=%0d want on=%0d per=%0d",
                    d, i, got[i][31:16], got[i][15:0], exp_q[i][31:16], exp_q[i][15:0]);
            end
        end
    endtask

    task automatic test_reset_mid_period;
        logic [63:0] got[$];
        do_reset(0);
        fill(3, 4, 6);
        play(0, 65535, 1'b0);
        drive(0, 1'b1, 5);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        pin_a = 1'b1;
        total++;
        if ({on_a, per_a, sv_a, ls_a, sl_a} !== 35'd0) begin
            bad++; $display("FAIL midreset_outputs got=%h want=0", {on_a, per_a, sv_a, ls_a, sl_a});
        end
        obs_a.delete();
        exp_q.delete();
        drive(0, 1'b0, 3);
        for (int i = 0; i < 3; i++)
            fill(1, $urandom_range(1, 9), $urandom_range(1, 9));
        play(0, 65535, 1'b1);
        got = obs_a;
        total++;
        if (got.size() != exp_q.size()) begin
            bad++; $display("FAIL midreset_count got=%0d want=%0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i][31:0] !== exp_q[i]) begin
                bad++; $display("FAIL midreset_sample[%0d] got on=%0d per=%0d want on=%0d per=%0d",
                    i, got[i][31:16], got[i][15:0], exp_q[i][31:16], exp_q[i][15:0]);
            end
        end
    endtask

    task automatic test_boundary_cnt4;
        logic [63:0] got[$];
        do_reset(2);
        fill(1, 1, 13);
        fill(1, 13, 1);
        fill(1, 7, 7);
        play(2, 15, 1'b1);
        got = obs_c;
        total++;
        if (got.size() != exp_q.size()) begin
            bad++; $display("FAIL bound_count got=%0d want=%0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i][31:0] !== exp_q[i]) begin
                bad++; $display("FAIL bound_sample[%0d] got on=%0d per=%0d want on=%0d per=%0d",
                    i, got[i][31:16], got[i][15:0], exp_q[i][31:16], exp_q[i][15:0]);
            end
        end
        total++;
        if (ls_c !== 1'b0) begin
            bad++; $display("FAIL bound_stuck got=%b want=0", ls_c);
        end
    endtask

    task automatic test_stuck_on_cnt4;
        logic [63:0] got[$];
        do_reset(2);
        fill(4, 3, 4);
        play(2, 15, 1'b0);
        drive(2, 1'b1, 40);
        got = obs_c;
        total++;
        if (got.size() != exp_q.size()) begin
            bad++; $display("FAIL ston_count got=%0d want=%0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i][31:0] !== exp_q[i]) begin
                bad++; $display("FAIL ston_sample[%0d] got on=%0d per=%0d want on=%0d per=%0d",
                    i, got[i][31:16], got[i][15:0], exp_q[i][31:16], exp_q[i][15:0]);
            end
        end
        total++;
        if ({ls_c, sl_c, on_c, per_c} !== {1'b1, 1'b1, 4'd3, 4'd7}) begin
            bad++; $display("FAIL ston_hold got ls=%b sl=%b on=%0d per=%0d want ls=1 sl=1 on=3 per=7",
                ls_c, sl_c, on_c, per_c);
        end
        drive(2, 1'b0, 5);
        total++;
        if ({ls_c, sl_c} !== 2'b10) begin
            bad++; $display("FAIL ston_fall got ls=%b sl=%b want ls=1 sl=0", ls_c, sl_c);
        end
        obs_c.delete();
        exp_q.delete();
        fill(3, 4, 4);
        play(2, 15, 1'b1);
        got = obs_c;
        total++;
        if (got.size() != exp_q.size()) begin
            bad++; $display("FAIL ston_recover_count got=%0d want=%0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i][31:0] !== exp_q[i]) begin
                bad++; $display("FAIL ston_recover[%0d] got on=%0d per=%0d want on=%0d per=%0d",
                    i, got[i][31:16], got[i][15:0], exp_q[i][31:16], exp_q[i][15:0]);
            end
        end
        total++;
        if ({ls_c, sl_c} !== 2'b00) begin
            bad++; $display("FAIL ston_clear got ls=%b sl=%b want 00", ls_c, sl_c);
        end
    endtask

    task automatic test_period_20_cnt4;
        logic [63:0] got[$];
        do_reset(2);
        stuck_seen_c = 1'b0;
        fill(1, 3, 4);
        fill(4, 5, 15);
        play(2, 15, 1'b1);
        got = obs_c;
        total++;
        if (got.size() != exp_q.size()) begin
            bad++; $display("FAIL p20_count got=%0d want=%0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i][31:0] !== exp_q[i]) begin
                bad++; $display("FAIL p20_sample[%0d] got on=%0d per=%0d want on=%0d per=%0d",
                    i, got[i][31:16], got[i][15:0], exp_q[i][31:16], exp_q[i][15:0]);
            end
        end
        total++;
        if (stuck_seen_c !== 1'b1) begin
            bad++; $display("FAIL p20_stuck_seen got=%b want=1", stuck_seen_c);
        end
        total++;
        if ({on_c, per_c} !== {4'd3, 4'd7}) begin
            bad++; $display("FAIL p20_hold got on=%0d per=%0d want on=3 per=7", on_c, per_c);
        end
    endtask

    task automatic test_stuck_off_long;
        logic [63:0] got[$];
        do_reset(0);
        drive(0, 1'b0, 65545);
        total++;
        if ({ls_a, sl_a} !== 2'b10) begin
            bad++; $display("FAIL stoff_flag got ls=%b sl=%b want ls=1 sl=0", ls_a, sl_a);
        end
        total++;
        if (obs_a.size() != 0) begin
            bad++; $display("FAIL stoff_no_sample got=%0d want=0", obs_a.size());
        end
        fill(3, 4, 4);
        play(0, 65535, 1'b1);
        got = obs_a;
        total++;
        if (got.size() != exp_q.size()) begin
            bad++; $display("FAIL stoff_count got=%0d want=%0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            total++;
            if (got[i][31:0] !== exp_q[i]) begin
                bad++; $display("FAIL stoff_sample[%0d] got on=%0d per=%0d want on=%0d per=%0d",
                    i, got[i][31:16], got[i][15:0], exp_q[i][31:16], exp_q[i][15:0]);
            end
        end
        total++;
        if (ls_a !== 1'b0) begin
            bad++; $display("FAIL stoff_clear got=%b want=0", ls_a);
        end
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        pin_a = 1'b1; pin_b = 1'b0; pin_c = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        @(negedge clk);
        test_reset;
        test_fixed_3_5;
        test_active_high_1_1;
        test_random(0);
        test_random(1);
        test_reset_mid_period;
        test_boundary_cnt4;
        test_stuck_on_cnt4;
        test_period_20_cnt4;
        test_stuck_off_long;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
